// File: rtl/commit_trace_checker.sv
// rtl/commit_trace_checker.sv - in-order commit trace checker against a golden expected stream
//
// Purpose: queues register-write, store and halt commit events from the cpu and
// compares them one by one against an expected-trace stream (exp_valid/exp_ready).
// Reports done/pass, sticky overflow, index of first mismatch, cycle and instruction counts.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   w_reg_write_en, w_rd,
//   w_reg_write_data                 writeback register commit
//   m_mem_write_en, m_addr, m_data   memory-stage store commit
//   hlt                              halt reached writeback
//   exp_valid, exp_ready,
//   exp_kind, exp_tag, exp_value     golden expected-entry stream (ready is combinational)
//   done, pass, err_overflow,
//   mismatch_idx, cycle_count,
//   inst_count                       status and statistics

module commit_trace_checker #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_reg_write_en,
  input  logic [3:0]  w_rd,
  input  logic [15:0] w_reg_write_data,
  input  logic        m_mem_write_en,
  input  logic [15:0] m_addr,
  input  logic [15:0] m_data,
  input  logic        hlt,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic [15:0] exp_tag,
  input  logic [15:0] exp_value,
  output logic        done,
  output logic        pass,
  output logic        err_overflow,
  output logic [31:0] mismatch_idx,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] K_REG   = 2'd0;
  localparam logic [1:0] K_STORE = 2'd1;
  localparam logic [1:0] K_HALT  = 2'd2;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

  state_t        state;
  logic [33:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          halt_queued;
  logic [31:0]   entry_cnt;

  logic          active, empty, timeout;
  logic [PW-1:0] used;
  logic [PW:0]   free_slots;
  logic [33:0]   push_data [4];
  logic [1:0]    push_req, push_cnt;
  logic          overflow_now, halt_push;
  logic [33:0]   head;
  logic          mismatch, halt_match, any_event;

  assign active  = (state == S_RUN) || (state == S_DRAIN);
  // Pointers carry one extra wrap bit: equal pointers mean empty, MSB-only difference means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign used    = wr_ptr - rd_ptr;
  assign free_slots = (PW+1)'(FIFO_DEPTH) - (PW+1)'(used);
  assign timeout = (cycle_count == 32'(MAX_CYCLES));
  assign any_event = hlt | w_reg_write_en | m_mem_write_en;

  // Compact this cycle's accepted events into slots 0..2 in REG, STORE, HALT order.
  always_comb begin
    push_data[0] = '0;
    push_data[1] = '0;
    push_data[2] = '0;
    push_data[3] = '0;
    push_req     = 2'd0;
    halt_push    = 1'b0;
    if (active && !halt_queued) begin
      if (w_reg_write_en) begin
        push_data[push_req] = {K_REG, 12'b0, w_rd, w_reg_write_data};
        push_req = push_req + 2'd1;
      end
      if (m_mem_write_en) begin
        push_data[push_req] = {K_STORE, m_addr, m_data};
        push_req = push_req + 2'd1;
      end
      if (hlt) begin
        push_data[push_req] = {K_HALT, 16'b0, 16'b0};
        push_req = push_req + 2'd1;
      end
    end
    // Free slots are counted before this cycle's pop, so a same-cycle pop never rescues an overflow.
    overflow_now = ((PW+1)'(push_req) > free_slots);
    push_cnt     = overflow_now ? free_slots[1:0] : push_req;
    // HALT is always last, so it lands only when nothing overflowed.
    halt_push    = active && !halt_queued && hlt && !overflow_now;
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign exp_ready = active && !empty && exp_valid;

  always_comb begin
    mismatch = (head[33:32] != exp_kind) || (exp_kind == 2'd3);
    if (head[33:32] != K_HALT && (head[31:16] != exp_tag || head[15:0] != exp_value))
      mismatch = 1'b1;
  end

  assign halt_match = exp_ready && !mismatch && (head[33:32] == K_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < push_cnt)
          mem[AW'(wr_ptr + PW'(k))] <= push_data[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      halt_queued  <= 1'b0;
      entry_cnt    <= '0;
      err_overflow <= 1'b0;
      mismatch_idx <= '0;
      cycle_count  <= '0;
      inst_count   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      if (halt_push)
        halt_queued <= 1'b1;
      if (exp_ready) begin
        rd_ptr    <= rd_ptr + PW'(1);
        entry_cnt <= entry_cnt + 32'd1;
      end
      if (active) begin
        if (!timeout)
          cycle_count <= cycle_count + 32'd1;
        if (any_event)
          inst_count <= inst_count + 32'd1;
        if (overflow_now)
          err_overflow <= 1'b1;
        if (exp_ready && mismatch)
          mismatch_idx <= entry_cnt;
        if (overflow_now || (exp_ready && mismatch) || timeout)
          state <= S_FAIL;
        else if (halt_match)
          state <= S_PASS;
        else if (halt_push)
          state <= S_DRAIN;
      end
    end
  end

  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

endmodule
